// File: rtl/clcd_char_writer.sv
// Character-stream front end for the 16x2 CLCD: turns characters and clear requests
// into address/data/clear beats for the signal generator while tracking the cursor.
module clcd_char_writer #(
   parameter int unsigned COLS       = 16,
   parameter logic [7:0]  ROW1_BASE  = 8'h40,
   parameter int unsigned CLEAR_WAIT = 164000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       i_init_done,
   input  logic [7:0] i_char,
   input  logic       i_char_valid,
   output logic       o_char_ready,
   input  logic       i_clear,
   output logic       o_busy,
   output logic [7:0] o_data,
   output logic       o_RS,
   output logic       o_RW,
   output logic       o_valid,
   input  logic       i_busy,
   output logic [3:0] o_col,
   output logic       o_row
);

   localparam int unsigned      CNT_W     = $clog2(CLEAR_WAIT + 1);
   localparam logic [3:0]       LAST_COL  = 4'(COLS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLEAR_WAIT - 1);
   localparam logic [7:0]       NEWLINE   = 8'h0A;
   localparam logic [7:0]       CMD_CLEAR = 8'h01;
   localparam logic [7:0]       CMD_DDRAM = 8'h80;

   typedef enum logic [2:0] {IDLE, ISSUE, ACK_WAIT, DONE_WAIT, CLR_DELAY} state_t;

   state_t           state_q, state_d;
   logic [3:0]       col_q, col_d;
   logic             row_q, row_d;
   logic             need_addr_q, need_addr_d;
   logic             clr_pend_q, clr_pend_d;
   logic             op_clr_q, op_clr_d;
   logic [7:0]       char_q, char_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_d, rs_d, ready_d, busy_d;
   logic [7:0]       data_d, addr_cmd;
   logic             accept;

   assign o_RW  = 1'b0;
   assign o_col = col_q;
   assign o_row = row_q;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q      <= IDLE;
         col_q        <= 4'd0;
         row_q        <= 1'b0;
         need_addr_q  <= 1'b1;
         clr_pend_q   <= 1'b0;
         op_clr_q     <= 1'b0;
         char_q       <= 8'h00;
         cnt_q        <= '0;
         o_valid      <= 1'b0;
         o_data       <= 8'h00;
         o_RS         <= 1'b0;
         o_char_ready <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         need_addr_q  <= need_addr_d;
         clr_pend_q   <= clr_pend_d;
         op_clr_q     <= op_clr_d;
         char_q       <= char_d;
         cnt_q        <= cnt_d;
         o_valid      <= valid_d;
         o_data       <= data_d;
         o_RS         <= rs_d;
         o_char_ready <= ready_d;
         o_busy       <= busy_d;
      end
   end

   // Next-state, cursor and beat generation
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      need_addr_d = need_addr_q;
      clr_pend_d  = clr_pend_q | i_clear;
      op_clr_d    = op_clr_q;
      char_d      = char_q;
      cnt_d       = cnt_q;
      valid_d     = 1'b0;
      data_d      = o_data;
      rs_d        = o_RS;
      addr_cmd    = CMD_DDRAM | (row_q ? ROW1_BASE : 8'h00) | {4'h0, col_q};
      accept      = (state_q == IDLE) & i_char_valid & o_char_ready & ~i_clear;

      case (state_q)
         IDLE: begin
            if (i_init_done && clr_pend_q) begin
               op_clr_d = 1'b1;
               state_d  = ISSUE;
            end else if (accept) begin
               if (i_char == NEWLINE) begin
                  row_d       = ~row_q;
                  col_d       = 4'd0;
                  need_addr_d = 1'b1;
               end else begin
                  char_d   = i_char;
                  op_clr_d = 1'b0;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!i_busy && i_init_done) begin
               valid_d = 1'b1;
               state_d = ACK_WAIT;
               if (op_clr_q) begin
                  data_d = CMD_CLEAR;
                  rs_d   = 1'b0;
               end else if (need_addr_q) begin
                  data_d = addr_cmd;
                  rs_d   = 1'b0;
               end else begin
                  data_d = char_q;
                  rs_d   = 1'b1;
               end
            end
         end
         ACK_WAIT: begin
            if (i_busy) state_d = DONE_WAIT;
         end
         DONE_WAIT: begin
            if (!i_busy) begin
               if (op_clr_q) begin
                  cnt_d   = '0;
                  state_d = CLR_DELAY;
               end else if (need_addr_q) begin
                  // Address beat done; the data beat follows unless init has dropped
                  need_addr_d = 1'b0;
                  state_d     = i_init_done ? ISSUE : IDLE;
               end else begin
                  state_d = IDLE;
                  if (col_q == LAST_COL) begin
                     col_d       = 4'd0;
                     row_d       = ~row_q;
                     need_addr_d = 1'b1;
                  end else begin
                     col_d = col_q + 4'd1;
                  end
               end
            end
         end
         CLR_DELAY: begin
            if (cnt_q == LAST_CNT) begin
               col_d       = 4'd0;
               row_d       = 1'b0;
               need_addr_d = 1'b1;
               clr_pend_d  = i_clear;
               op_clr_d    = 1'b0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE) & i_init_done & ~clr_pend_d & ~accept;
      busy_d  = (state_d != IDLE) | clr_pend_d;
   end

endmodule

// File: tb/tb_clcd_char_writer.sv
// Directed bench for clcd_char_writer: a cursor model pushes expected beats,
// a monitor pops and compares them whenever the DUT strobes o_valid.
module tb_clcd_char_writer;

   localparam int unsigned CW = 40;

   logic       clk, reset_p, i_init_done, i_char_valid, i_clear, i_busy;
   logic [7:0] i_char, o_data;
   logic       o_char_ready, o_busy, o_RS, o_RW, o_valid, o_row;
   logic [3:0] o_col;

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   logic [8:0] exp_q[$];
   int  m_col = 0;
   bit  m_row = 0;
   bit  m_need = 1;
   bit  sg_enable = 1;
   bit  prev_valid = 0;

   clcd_char_writer #(.COLS(16), .ROW1_BASE(8'h40), .CLEAR_WAIT(CW)) dut (
      .clk(clk), .reset_p(reset_p), .i_init_done(i_init_done), .i_char(i_char),
      .i_char_valid(i_char_valid), .o_char_ready(o_char_ready), .i_clear(i_clear),
      .o_busy(o_busy), .o_data(o_data), .o_RS(o_RS), .o_RW(o_RW), .o_valid(o_valid),
      .i_busy(i_busy), .o_col(o_col), .o_row(o_row)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signal-generator stand-in: acknowledges each beat with a short busy pulse
   initial begin
      i_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (o_valid && sg_enable && !reset_p) begin
            @(negedge clk);
            i_busy = 1'b1;
            repeat (3) @(negedge clk);
            i_busy = 1'b0;
         end
      end
   end

   // Beat monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (o_valid) begin
            beat_cnt++;
            chk("valid_one_cycle", 32'(prev_valid), 32'd0);
            chk("rw_zero", 32'(o_RW), 32'd0);
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("beat", 32'({o_RS, o_data}), 32'(exp_q.pop_front()));
         end
         prev_valid = o_valid;
      end
   end

   function automatic void model_char(input logic [7:0] ch);
      if (ch == 8'h0A) begin
         m_row  = ~m_row;
         m_col  = 0;
         m_need = 1;
      end else begin
         if (m_need) exp_q.push_back({1'b0, 8'h80 | (m_row ? 8'h40 : 8'h00) | 8'(m_col)});
         exp_q.push_back({1'b1, ch});
         m_need = 0;
         if (m_col == 15) begin
            m_col  = 0;
            m_row  = ~m_row;
            m_need = 1;
         end else begin
            m_col++;
         end
      end
   endfunction

   task automatic send_char(input logic [7:0] ch);
      bit done = 0;
      model_char(ch);
      i_char       = ch;
      i_char_valid = 1'b1;
      for (int i = 0; i < 500 && !done; i++) begin
         if (o_char_ready) begin
            @(posedge clk);
            done = 1;
         end
         @(negedge clk);
      end
      i_char_valid = 1'b0;
      chk("accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (o_char_ready && !o_busy) done = 1;
      end
      chk("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_valid();
      bit done = 0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (o_valid) done = 1;
      end
      chk("valid_timeout", 32'(done), 32'd1);
   endtask

   task automatic chk_cursor(input string tag, input int col, input bit row);
      chk({tag, "_col"}, 32'(o_col), 32'(col));
      chk({tag, "_row"}, 32'(o_row), 32'(row));
   endtask

   initial begin
      int bc;
      int rdy_seen;
      int hold;
      reset_p = 1'b1; i_init_done = 1'b0; i_char = 8'h00; i_char_valid = 1'b0; i_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_rs", 32'(o_RS), 32'd0);
      chk("rst_ready", 32'(o_char_ready), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk_cursor("rst", 0, 0);
      reset_p = 1'b0;
      @(negedge clk);
      i_init_done = 1'b1;
      @(negedge clk);
      chk("ready_after_init", 32'(o_char_ready), 32'd1);

      // Single character with leading address
      send_char(8'h41);
      wait_idle();
      chk_cursor("after_A", 1, 0);

      // Two newlines return to row 0 col 0 without any beat
      bc = beat_cnt;
      send_char(8'h0A);
      wait_idle();
      chk_cursor("nl1", 0, 1);
      send_char(8'h0A);
      wait_idle();
      chk("nl_no_beat", 32'(beat_cnt), 32'(bc));

      // Fill row 0, then wrap to row 1
      for (int i = 0; i < 16; i++) send_char(8'(8'h61 + i));
      send_char(8'h71);
      wait_idle();
      chk_cursor("row_wrap", 1, 1);

      // Row 1 wraps back to row 0
      for (int i = 0; i < 14; i++) send_char(8'(8'h30 + i));
      send_char(8'h5A);
      send_char(8'h59);
      wait_idle();
      chk_cursor("row1_wrap", 1, 0);

      // Newline mid-row
      for (int i = 0; i < 4; i++) send_char(8'(8'h4B + i));
      wait_idle();
      chk_cursor("col5", 5, 0);
      bc = beat_cnt;
      send_char(8'h0A);
      wait_idle();
      chk("nl_mid_no_beat", 32'(beat_cnt), 32'(bc));
      send_char(8'h42);
      wait_idle();
      chk_cursor("after_B", 1, 1);

      // Clear during a data beat
      send_char(8'h43);
      wait_valid();
      i_clear = 1'b1;
      exp_q.push_back({1'b0, 8'h01});
      m_col = 0; m_row = 0; m_need = 1;
      @(negedge clk);
      i_clear = 1'b0;
      wait_valid();
      hold = 0;
      for (int i = 0; i < 500 && o_busy; i++) begin
         @(negedge clk);
         hold++;
      end
      chk("clr_hold_min", 32'(hold >= CW), 32'd1);
      chk("clr_hold_max", 32'(hold <= CW + 20), 32'd1);
      chk_cursor("after_clr", 0, 0);
      send_char(8'h44);
      wait_idle();
      chk_cursor("after_D", 1, 0);

      // Init low blocks characters
      i_init_done = 1'b0;
      repeat (2) @(negedge clk);
      bc = beat_cnt;
      rdy_seen = 0;
      i_char = 8'h45;
      i_char_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (o_char_ready) rdy_seen++;
      end
      chk("init_low_ready", 32'(rdy_seen), 32'd0);
      chk("init_low_beats", 32'(beat_cnt), 32'(bc));
      i_init_done = 1'b1;
      send_char(8'h45);
      wait_idle();
      chk_cursor("after_E", 2, 0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset while the beat strobe is high in ACK_WAIT
      sg_enable = 0;
      send_char(8'h52);
      wait_valid();
      #2 reset_p = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(o_valid), 32'd0);
      chk("rst_mid_busy", 32'(o_busy), 32'd0);
      chk_cursor("rst_mid", 0, 0);
      exp_q.delete();
      m_col = 0; m_row = 0; m_need = 1;
      sg_enable = 1;
      @(negedge clk);
      reset_p = 1'b0;
      send_char(8'h53);
      wait_idle();
      chk_cursor("after_S", 1, 0);
      chk("queue_final", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
